// File: rtl/ssp_frame_pkg.sv
// rtl/ssp_frame_pkg.sv - shared state type, WnR encoding and frame geometry helpers for the SSP frame slave
package ssp_frame_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;

  localparam logic WNR_WRITE = 1'b1;
  localparam logic WNR_READ  = 1'b0;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int frame_len(input int ch_w, input int addr_w, input int data_w);
    return ch_w + addr_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/ssp_sync_edge.sv
// rtl/ssp_sync_edge.sv - multi-stage input synchroniser with rise/fall detection on the synchronised level
module ssp_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ssp_frame_slave.sv
// rtl/ssp_frame_slave.sv - oversampling SSP slave that decodes channel/address/WnR/data frames into register strobes
module ssp_frame_slave
  import ssp_frame_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  ADDR_W      = 3,
  parameter int  DATA_W      = 12,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              SSP_SSEL,
  input  logic              SSP_SCK,
  input  logic              SSP_MOSI,
  output logic              SSP_MISO,
  output logic              SSP_MISO_OE,
  output logic              wr_en,
  output logic              rd_req,
  output logic [CH_W-1:0]   reg_ch,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err_abort,
  output logic              err_chan
);

  localparam int FLEN    = frame_len(CH_W, ADDR_W, DATA_W);
  localparam int HDR_LEN = CH_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(FLEN + 1);
  localparam int RX_W    = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FLEN - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic ssel_s, ssel_rise, ssel_fall;
  logic sck_s, rise_sck, fall_sck;
  logic mosi_s, mosi_rise, mosi_fall;

  ssp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
    .clk_i(Clk), .rst_i(Rst), .d_i(SSP_SSEL), .q_o(ssel_s), .rise_o(ssel_rise), .fall_o(ssel_fall));
  ssp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(Clk), .rst_i(Rst), .d_i(SSP_SCK), .q_o(sck_s), .rise_o(rise_sck), .fall_o(fall_sck));
  ssp_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(Clk), .rst_i(Rst), .d_i(SSP_MOSI), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_s, mosi_rise, mosi_fall};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RX_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wnr_q, wnr_d, bad_q, bad_d, miso_q, miso_d;
  logic              wr_en_q, wr_en_d, rd_req_q, rd_req_d, rd_cap_q, rd_cap_d;
  logic              abort_q, abort_d, chan_q, chan_d, armed_q, armed_d;
  logic [SYNC_STAGES:0] settle_q, settle_d;

  logic [RX_W-1:0]    rx_shift;
  logic [HDR_LEN-1:0] hdr;
  logic [CH_W-1:0]    hdr_ch;
  logic               hdr_bad;

  assign rx_shift = {rx_q, mosi_s};
  assign hdr      = rx_shift[HDR_LEN-1:0];
  assign hdr_ch   = hdr[HDR_LEN-1 -: CH_W];
  assign hdr_bad  = ({1'b0, hdr_ch} >= CH_LIMIT);

  // After reset the synchronisers briefly show SSEL high; a frame is only
  // accepted once SSEL has genuinely been seen high after they have flushed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    wnr_d     = wnr_q;
    bad_d     = bad_q;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    rd_req_d  = 1'b0;
    rd_cap_d  = rd_req_q;
    abort_d   = 1'b0;
    chan_d    = 1'b0;
    settle_d  = {settle_q[SYNC_STAGES-1:0], 1'b1};
    armed_d   = armed_q | (settle_q[SYNC_STAGES] & ssel_s);

    if (rd_cap_q) tx_d = rd_data;

    unique case (state_q)
      IDLE: begin
        if (ssel_fall && armed_q) begin
          state_d = HDR;
          cnt_d   = '0;
          tx_d    = '0;
          miso_d  = 1'b0;
        end
      end
      HDR: begin
        if (ssel_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (rise_sck) begin
          rx_d  = rx_shift[RX_W-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == HDR_LAST) begin
            state_d  = DATA;
            ch_d     = hdr_ch;
            addr_d   = hdr[ADDR_W:1];
            wnr_d    = hdr[0];
            bad_d    = hdr_bad;
            chan_d   = hdr_bad;
            rd_req_d = (hdr[0] == WNR_READ) && !hdr_bad;
          end
        end
      end
      DATA: begin
        if (ssel_rise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (fall_sck) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (rise_sck) begin
            rx_d  = rx_shift[RX_W-2:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == FRM_LAST) begin
              state_d = DONE;
              miso_d  = 1'b0;
              if (wnr_q == WNR_WRITE && !bad_q) begin
                wr_en_d   = 1'b1;
                wr_data_d = rx_shift[DATA_W-1:0];
              end
            end
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ssel_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      wnr_q     <= 1'b0;
      bad_q     <= 1'b0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_cap_q  <= 1'b0;
      abort_q   <= 1'b0;
      chan_q    <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      wnr_q     <= wnr_d;
      bad_q     <= bad_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      rd_req_q  <= rd_req_d;
      rd_cap_q  <= rd_cap_d;
      abort_q   <= abort_d;
      chan_q    <= chan_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
    end
  end

  assign SSP_MISO    = miso_q;
  assign SSP_MISO_OE = ~ssel_s;
  assign wr_en       = wr_en_q;
  assign rd_req      = rd_req_q;
  assign reg_ch      = ch_q;
  assign reg_addr    = addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign err_abort   = abort_q;
  assign err_chan    = chan_q;

endmodule

// File: tb/tb_ssp_frame_slave.sv
// tb/tb_ssp_frame_slave.sv - directed self-checking bench for ssp_frame_slave (4-channel and 3-channel instances)
module tb_ssp_frame_slave;

  localparam int HALF = 6;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        SSP_SSEL = 1'b1;
  logic        SSP_SCK = 1'b0;
  logic        SSP_MOSI = 1'b0;
  logic [11:0] rd_data = 12'h000;

  logic        SSP_MISO, SSP_MISO_OE, wr_en, rd_req, busy, err_abort, err_chan;
  logic [1:0]  reg_ch;
  logic [2:0]  reg_addr;
  logic [11:0] wr_data;

  logic        miso3, oe3, wr_en3, rd_req3, busy3, abort3, chan3;
  logic [1:0]  reg_ch3;
  logic [2:0]  reg_addr3;
  logic [11:0] wr_data3;

  always #5 Clk = ~Clk;

  ssp_frame_slave dut (
    .Clk(Clk), .Rst(Rst), .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_MOSI(SSP_MOSI),
    .SSP_MISO(SSP_MISO), .SSP_MISO_OE(SSP_MISO_OE), .wr_en(wr_en), .rd_req(rd_req),
    .reg_ch(reg_ch), .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .err_abort(err_abort), .err_chan(err_chan));

  ssp_frame_slave #(.NUM_CH(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_MOSI(SSP_MOSI),
    .SSP_MISO(miso3), .SSP_MISO_OE(oe3), .wr_en(wr_en3), .rd_req(rd_req3),
    .reg_ch(reg_ch3), .reg_addr(reg_addr3), .wr_data(wr_data3), .rd_data(rd_data),
    .busy(busy3), .err_abort(abort3), .err_chan(chan3));

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt, rd_cnt, abort_cnt, chan_cnt, wr_cnt3, rd_cnt3, chan_cnt3;
  logic [1:0]  wr_ch, rd_ch;
  logic [2:0]  wr_addr, rd_addr;
  logic [11:0] wr_val;
  logic [31:0] miso_vec, miso3_vec;
  logic        rd_req_prev = 1'b0;
  logic [11:0] rd_value = 12'h3C7;

  // Register-file model: read data is presented only during the cycle after rd_req.
  always @(negedge Clk) begin
    rd_data     = rd_req_prev ? rd_value : 12'h000;
    rd_req_prev = rd_req;
  end

  always @(negedge Clk) begin
    if (wr_en)  begin wr_cnt++; wr_ch = reg_ch; wr_addr = reg_addr; wr_val = wr_data; end
    if (rd_req) begin rd_cnt++; rd_ch = reg_ch; rd_addr = reg_addr; end
    if (err_abort) abort_cnt++;
    if (err_chan)  chan_cnt++;
    if (wr_en3)  wr_cnt3++;
    if (rd_req3) rd_cnt3++;
    if (chan3)   chan_cnt3++;
  end

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; abort_cnt = 0; chan_cnt = 0;
    wr_cnt3 = 0; rd_cnt3 = 0; chan_cnt3 = 0;
    wr_ch = '0; wr_addr = '0; wr_val = '0; rd_ch = '0; rd_addr = '0;
  endtask

  task automatic frame_begin();
    clear_counts();
    miso_vec = '0; miso3_vec = '0;
    SSP_SSEL = 1'b0;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge Clk);
    SSP_SSEL = 1'b1;
    repeat (10) @(negedge Clk);
  endtask

  task automatic sck_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SSP_MOSI = bits[i];
      repeat (HALF) @(negedge Clk);
      SSP_SCK   = 1'b1;
      miso_vec  = {miso_vec[30:0], SSP_MISO};
      miso3_vec = {miso3_vec[30:0], miso3};
      repeat (HALF) @(negedge Clk);
      SSP_SCK = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({wr_en, rd_req, busy, err_abort, err_chan, SSP_MISO, SSP_MISO_OE} !== 7'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000000", {wr_en, rd_req, busy, err_abort, err_chan, SSP_MISO, SSP_MISO_OE});
    end
    n_cmp++;
    if ({reg_ch, reg_addr, wr_data} !== 17'h0) begin
      n_err++; $display("FAIL reset_fields: got %h want 0", {reg_ch, reg_addr, wr_data});
    end
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_write();
    frame_begin();
    sck_bits({14'd0, 2'd2, 3'd5, 1'b1, 12'hA5C}, 18);
    repeat (HALF) @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL write_busy_hold: got %b want 1", busy); end
    SSP_SSEL = 1'b1;
    repeat (10) @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL write_busy_fall: got %b want 0", busy); end
    n_cmp++;
    if (wr_cnt !== 1) begin n_err++; $display("FAIL write_count: got %0d want 1", wr_cnt); end
    n_cmp++;
    if ({wr_ch, wr_addr, wr_val} !== {2'd2, 3'd5, 12'hA5C}) begin
      n_err++; $display("FAIL write_fields: got ch=%0d addr=%0d data=%h want ch=2 addr=5 data=a5c", wr_ch, wr_addr, wr_val);
    end
    n_cmp++;
    if (rd_cnt !== 0 || miso_vec[17:0] !== 18'h0) begin
      n_err++; $display("FAIL write_no_read: got rd=%0d miso=%h want 0 0", rd_cnt, miso_vec[17:0]);
    end
  endtask

  task automatic test_read();
    frame_begin();
    sck_bits({14'd0, 2'd1, 3'd3, 1'b0, 12'h000}, 18);
    frame_end();
    n_cmp++;
    if (rd_cnt !== 1 || wr_cnt !== 0) begin
      n_err++; $display("FAIL read_counts: got rd=%0d wr=%0d want 1 0", rd_cnt, wr_cnt);
    end
    n_cmp++;
    if ({rd_ch, rd_addr} !== {2'd1, 3'd3}) begin
      n_err++; $display("FAIL read_fields: got ch=%0d addr=%0d want 1 3", rd_ch, rd_addr);
    end
    n_cmp++;
    if (miso_vec[17:0] !== 18'h003C7) begin
      n_err++; $display("FAIL read_miso: got %h want 003c7", miso_vec[17:0]);
    end
    n_cmp++;
    if ({reg_ch, reg_addr} !== {2'd1, 3'd3}) begin
      n_err++; $display("FAIL read_fields_held: got %0d/%0d want 1/3", reg_ch, reg_addr);
    end
  endtask

  task automatic test_abort();
    frame_begin();
    sck_bits({22'd0, 2'd2, 3'd5, 1'b1, 4'hF}, 10);
    frame_end();
    n_cmp++;
    if (abort_cnt !== 1 || wr_cnt !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort: got abort=%0d wr=%0d busy=%b want 1 0 0", abort_cnt, wr_cnt, busy);
    end
    frame_begin();
    sck_bits({14'd0, 2'd3, 3'd1, 1'b1, 12'h123}, 18);
    frame_end();
    n_cmp++;
    if (wr_cnt !== 1 || {wr_ch, wr_addr, wr_val} !== {2'd3, 3'd1, 12'h123} || abort_cnt !== 0) begin
      n_err++; $display("FAIL abort_recover: got wr=%0d ch=%0d addr=%0d data=%h abort=%0d want 1 3 1 123 0",
                        wr_cnt, wr_ch, wr_addr, wr_val, abort_cnt);
    end
  endtask

  task automatic test_bad_chan();
    frame_begin();
    sck_bits({14'd0, 2'd3, 3'd2, 1'b1, 12'hFFF}, 18);
    frame_end();
    n_cmp++;
    if (chan_cnt3 !== 1 || wr_cnt3 !== 0 || miso3_vec[17:0] !== 18'h0) begin
      n_err++; $display("FAIL badch_write: got chan=%0d wr=%0d miso=%h want 1 0 0", chan_cnt3, wr_cnt3, miso3_vec[17:0]);
    end
    n_cmp++;
    if (wr_cnt !== 1 || chan_cnt !== 0 || wr_val !== 12'hFFF) begin
      n_err++; $display("FAIL badch_valid4: got wr=%0d chan=%0d data=%h want 1 0 fff", wr_cnt, chan_cnt, wr_val);
    end
    frame_begin();
    sck_bits({14'd0, 2'd3, 3'd2, 1'b0, 12'h000}, 18);
    frame_end();
    n_cmp++;
    if (chan_cnt3 !== 1 || rd_cnt3 !== 0 || miso3_vec[17:0] !== 18'h0) begin
      n_err++; $display("FAIL badch_read: got chan=%0d rd=%0d miso=%h want 1 0 0", chan_cnt3, rd_cnt3, miso3_vec[17:0]);
    end
    n_cmp++;
    if (miso_vec[17:0] !== 18'h003C7) begin
      n_err++; $display("FAIL badch_read_valid4: got %h want 003c7", miso_vec[17:0]);
    end
  endtask

  task automatic test_extra_sck();
    frame_begin();
    sck_bits({12'd0, 2'd0, 3'd7, 1'b1, 12'h5A3, 2'b11}, 20);
    repeat (HALF) @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b1 || wr_cnt !== 1 || wr_val !== 12'h5A3 || wr_addr !== 3'd7) begin
      n_err++; $display("FAIL extra_sck: got busy=%b wr=%0d data=%h addr=%0d want 1 1 5a3 7", busy, wr_cnt, wr_val, wr_addr);
    end
    SSP_SSEL = 1'b1;
    repeat (10) @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b0 || abort_cnt !== 0 || wr_cnt !== 1) begin
      n_err++; $display("FAIL extra_sck_end: got busy=%b abort=%0d wr=%0d want 0 0 1", busy, abort_cnt, wr_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [17:0] bits = {2'd2, 3'd1, 1'b1, 12'hFFF};
    frame_begin();
    sck_bits({20'd0, bits[17:6]}, 12);
    SSP_MOSI = bits[5];
    repeat (HALF) @(negedge Clk);
    SSP_SCK = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({wr_en, rd_req, busy, err_abort, err_chan, SSP_MISO, SSP_MISO_OE} !== 7'b0 ||
        {reg_ch, reg_addr, wr_data} !== 17'h0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %b %h want 0 0",
                        {wr_en, rd_req, busy, err_abort, err_chan, SSP_MISO, SSP_MISO_OE}, {reg_ch, reg_addr, wr_data});
    end
    Rst = 1'b0;
    repeat (HALF - 3) @(negedge Clk);
    SSP_SCK = 1'b0;
    sck_bits({27'd0, bits[4:0]}, 5);
    frame_end();
    n_cmp++;
    if (wr_cnt !== 0 || abort_cnt !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ignored: got wr=%0d abort=%0d busy=%b want 0 0 0", wr_cnt, abort_cnt, busy);
    end
    frame_begin();
    sck_bits({14'd0, 2'd1, 3'd6, 1'b1, 12'h0F0}, 18);
    frame_end();
    n_cmp++;
    if (wr_cnt !== 1 || {wr_ch, wr_addr, wr_val} !== {2'd1, 3'd6, 12'h0F0}) begin
      n_err++; $display("FAIL rst_mid_fresh: got wr=%0d ch=%0d addr=%0d data=%h want 1 1 6 0f0", wr_cnt, wr_ch, wr_addr, wr_val);
    end
  endtask

  initial begin
    clear_counts();
    miso_vec = '0;
    miso3_vec = '0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_bad_chan();
    test_extra_sck();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_frame_slave.md
Name: ssp_frame_slave

Overview:
Parametrised SSP slave front end for the multi-channel UART generation. It oversamples SSP_SSEL/SSP_SCK/SSP_MOSI in the Clk domain and deserialises each frame into channel, register address, command and data fields. It issues single-cycle register write or read strobes to NUM_CH UART channel register files, and shifts read data back on SSP_MISO. It replaces the fixed 3-bit-address, 12-bit-data, single-channel SSP port.

Parameters:
NUM_CH, 4, number of UART channels addressed; CH_W = max(1, clog2(NUM_CH)) localparam
ADDR_W, 3, register address field width per channel
DATA_W, 12, register data field width
SYNC_STAGES, 2, synchroniser depth on SSP inputs (>=2)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
SSP_SSEL  in  1  slave select, active low
SSP_SCK  in  1  serial clock, CPOL=0/CPHA=0 (sample on rise, shift on fall)
SSP_MOSI  in  1  serial data in, MSB first
SSP_MISO  out  1  serial data out
SSP_MISO_OE  out  1  MISO drive enable (high while SSEL low)
wr_en  out  1  one-cycle register write strobe
rd_req  out  1  one-cycle register read request
reg_ch  out  CH_W  channel of current access
reg_addr  out  ADDR_W  register address
wr_data  out  DATA_W  write data, valid with wr_en
rd_data  in  DATA_W  read data, valid exactly 1 Clk after rd_req
busy  out  1  frame in progress
err_abort  out  1  one-cycle pulse, frame truncated
err_chan  out  1  one-cycle pulse, channel >= NUM_CH

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is Clk, reset port is Rst.
- Reset: all outputs 0, state IDLE, synchronisers cleared to SSEL=1, SCK=0.
- Inputs pass SYNC_STAGES flops. Edges are detected on the synchronised signals: rise_sck, fall_sck, ssel_fall, ssel_rise.
- Timing constraint: SCK high and low each >= SYNC_STAGES+2 Clk cycles.
- Frame = CH_W channel bits, then ADDR_W address bits, then 1 WnR bit (1=write), then DATA_W data bits, all MSB first. FLEN = CH_W+ADDR_W+1+DATA_W.
- State machine:
  - IDLE: wait for ssel_fall, then go to HDR and clear the bit counter.
  - HDR: sample MOSI on each rise_sck. After the WnR bit go to DATA. If WnR=0, pulse rd_req in that same cycle with reg_ch/reg_addr.
  - DATA: sample DATA_W bits. On the last rise_sck, if WnR=1, pulse wr_en with wr_data. Then go to DONE.
  - DONE: further SCK edges are ignored and MISO=0. On ssel_rise go to IDLE.
- Read path: rd_data is captured into the TX shift register on the cycle after rd_req. Each fall_sck in DATA drives the next bit MSB first, so the first bit appears on the fall_sck following the WnR sample. MISO is 0 in HDR and in write frames.
- reg_ch and reg_addr are held stable from the WnR sample until the next frame starts.
- Channel >= NUM_CH (non-power-of-2 NUM_CH): wr_en and rd_req are suppressed and MISO shifts zeros. err_chan pulses at the WnR sample.
- ssel_rise in HDR or DATA: return to IDLE, no wr_en, err_abort pulses one cycle. A read already requested is not retracted.
- ssel_rise and rise_sck in the same cycle: the abort wins and that bit is discarded.
- busy = 1 from ssel_fall until the IDLE return.
- Rst mid-frame: immediate IDLE with no strobes. The remainder of that SSEL-low window is ignored until ssel_rise, then ssel_fall.
- Bit counter width is clog2(FLEN+1). Counting saturates in DONE with no wrap.

Decomposition:
- Package ssp_frame_pkg: state enum (IDLE, HDR, DATA, DONE), functions for CH_W and FLEN, WnR encoding constants.
- One sub-module: ssp_sync_edge (SYNC_STAGES synchroniser plus rise/fall detect), instantiated three times.

Test Plan:
- NUM_CH=4, ADDR_W=3, DATA_W=12, write frame ch=2, addr=5, data=0xA5C -> exactly one wr_en with reg_ch=2, reg_addr=5, wr_data=0xA5C, busy falls after SSEL high.
- Read frame ch=1, addr=3, rd_data=0x3C7 returned 1 cycle after rd_req -> MISO bits equal 0x3C7 MSB first on the 12 data rise edges, no wr_en.
- SSEL deasserted after 10 of 18 bits -> err_abort pulse, no wr_en, next full write frame is decoded correctly.
- NUM_CH=3, frame ch=3 write 0xFFF -> err_chan pulse, no wr_en, MISO stays 0.
- 20 SCK pulses in one SSEL window (2 extra) -> one wr_en only, extra bits ignored, DONE until SSEL high.
- Rst asserted during DATA bit 6 of a write -> all outputs 0 next cycle, no wr_en. A fresh frame after an SSEL cycle is decoded.
